// File: rtl/eff_tremolo.sv
// ============================================================================
// Module  : eff_tremolo
// Brief   : Tremolo effect. Offset-binary samples are amplitude-modulated by
//           a triangle LFO that advances on valid samples. Fixed 2-cycle latency.
//           Define EFF_TREMOLO_SQUARE_EN to drive the gain from a square LFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module eff_tremolo #(
  parameter int DATA_WIDTH = 12,
  parameter int RATE_DIV   = 64,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  vld_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o
);

  localparam int                  CW       = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int                  PW       = DATA_WIDTH + 10;
  localparam logic [CW-1:0]       DIV_LAST = CW'(RATE_DIV - 1);
  localparam logic [16:0]         DEPTH_C  = 17'(DEPTH);
  localparam logic [DATA_WIDTH:0] MID_C    = {2'b01, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MID_OUT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfo_q, lfo_d;
  dir_e          dir_q, dir_d;

  logic [7:0]              lfo_eff;
  logic [16:0]             scale;
  logic [8:0]              gain;
  logic signed [DATA_WIDTH:0] cen;
  logic signed [PW-1:0]    prod;

  logic                  vld1_q, en1_q;
  logic [DATA_WIDTH-1:0] scaled1_q, raw1_q;
  logic [DATA_WIDTH-1:0] data_d;

  // LFO is parked at its reset state while bypassed so enabling starts at unity gain.
  always_comb begin
    cnt_d = cnt_q;
    lfo_d = lfo_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      lfo_d = '0;
      dir_d = DIR_UP;
    end else if (vld_i) begin
      if (cnt_q == DIV_LAST) begin
        cnt_d = '0;
        if (dir_q == DIR_UP) begin
          if (lfo_q == 8'hFF) begin
            dir_d = DIR_DN;
            lfo_d = 8'hFE;
          end else begin
            lfo_d = lfo_q + 8'd1;
          end
        end else begin
          if (lfo_q == 8'h00) begin
            dir_d = DIR_UP;
            lfo_d = 8'h01;
          end else begin
            lfo_d = lfo_q - 8'd1;
          end
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef EFF_TREMOLO_SQUARE_EN
  assign lfo_eff = (dir_q == DIR_DN) ? 8'hFF : 8'h00;
`else
  assign lfo_eff = lfo_q;
`endif

  assign scale = {9'd0, lfo_eff} * DEPTH_C;
  assign gain  = 9'd256 - 9'(scale >> 8);
  assign cen   = $signed({1'b0, data_i} - MID_C);
  assign prod  = PW'(cen) * $signed(PW'({1'b0, gain}));

  // Only the low DATA_WIDTH bits of the shifted product matter: the final
  // result always fits, so adding the midpoint modulo 2^DATA_WIDTH is exact.
  assign data_d = en1_q ? (scaled1_q + MID_OUT) : raw1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      lfo_q     <= '0;
      dir_q     <= DIR_UP;
      vld1_q    <= 1'b0;
      en1_q     <= 1'b0;
      scaled1_q <= '0;
      raw1_q    <= '0;
      data_o    <= '0;
      vld_o     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lfo_q  <= lfo_d;
      dir_q  <= dir_d;
      vld1_q <= vld_i;
      vld_o  <= vld1_q;
      if (vld_i) begin
        en1_q     <= en;
        scaled1_q <= DATA_WIDTH'(prod >>> 8);
        raw1_q    <= data_i;
      end
      if (vld1_q) begin
        data_o <= data_d;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eff_tremolo.sv
// ============================================================================
// Module  : tb_eff_tremolo
// Brief   : Directed self-checking bench for eff_tremolo (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eff_tremolo;

  localparam int RATE  = 64;
  localparam int DEPTH = 128;
  localparam int MID   = 2048;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        en     = 1'b0;
  logic        vld_i  = 1'b0;
  logic [11:0] data_i = '0;
  logic [11:0] data_o;
  logic        vld_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   nval     = 0;
  int   last_out = 0;
  logic v_prev   = 1'b0;
  int   exp_q[$];

  always #5 clk = ~clk;

  eff_tremolo #(
    .DATA_WIDTH (12),
    .RATE_DIV   (RATE),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .data_i (data_i),
    .vld_i  (vld_i),
    .data_o (data_o),
    .vld_o  (vld_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Triangle position after n enabled valid samples.
  function automatic int lfo_of(input int n);
    int s;
    s = (n / RATE) % 510;
    return (s <= 255) ? s : 510 - s;
  endfunction

  function automatic int model(input int lfo, input int d);
    int c, g, p, q;
    c = d - MID;
    g = 256 - (lfo * DEPTH) / 256;
    p = c * g;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return MID + q;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive, queue expectation (hand value if hand >= 0), check outputs.
  task automatic cyc(input logic v, input logic e, input logic [11:0] d, input int hand);
    int ex;
    vld_i  = v;
    en     = e;
    data_i = d;
    if (!e) nval = 0;
    if (v) begin
      if (!e)            ex = int'(d);
      else if (hand >= 0) ex = hand;
      else               ex = model(lfo_of(nval), int'(d));
      if (e) nval++;
      exp_q.push_back(ex);
    end
    tick();
    check("vld_o", int'(vld_o), int'(v_prev));
    v_prev = v;
    if (vld_o) begin
      if (exp_q.size() == 0) check("spurious_vld", 1, 0);
      else                   check("data_o", int'(data_o), exp_q.pop_front());
      last_out = int'(data_o);
    end else begin
      check("data_hold", int'(data_o), last_out);
    end
  endtask

  initial begin
    int          h;
    logic        v;
    logic [11:0] d;

    repeat (3) tick();
    check("rst_data_o", int'(data_o), 0);
    check("rst_vld_o", int'(vld_o), 0);
    rst = 1'b1;

    // Bypass stream.
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 12'h123, -1);

    // Tremolo, continuous valids up to the top of the triangle.
    for (int i = 0; i < 256 * RATE; i++) begin
      d = 12'h123;
      h = -1;
      if (i < 2 * RATE)          h = 'h123;
      else if (i < 3 * RATE)     h = 'h129;
      else if (i == 255 * RATE)  h = 'h48A;
      else if (i == 255 * RATE + 1) begin d = 12'h800; h = 'h800; end
      else if (i == 255 * RATE + 2) begin d = 12'hFFF; h = 'hC07; end
      cyc(1'b1, 1'b1, d, h);
    end

    // Sparse valids through one full period and into the next.
    while (nval < 510 * RATE + 130) begin
      v = ($urandom_range(0, 2) != 0);
      d = 12'($urandom);
      h = -1;
      if (v) begin
        if (nval == 508 * RATE)      begin d = 12'h123; h = 'h129; end
        else if (nval == 509 * RATE) begin d = 12'h123; h = 'h123; end
        else if (nval == 510 * RATE) begin d = 12'h123; h = 'h123; end
        else if (nval == 512 * RATE) begin d = 12'h123; h = 'h129; end
      end
      cyc(v, 1'b1, d, h);
    end
    cyc(1'b0, 1'b1, 12'h000, -1);
    cyc(1'b0, 1'b1, 12'h000, -1);

    // Mode switch mid-stream; re-enable restarts at unity gain.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 12'hFFF, -1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 12'hFFF, 'hFFF);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 12'hFFF, 'hFFF);

    // Asynchronous reset with samples in flight.
    cyc(1'b1, 1'b1, 12'h123, -1);
    cyc(1'b1, 1'b1, 12'h123, -1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_data_o", int'(data_o), 0);
    check("arst_vld_o", int'(vld_o), 0);
    tick();
    check("arst_hold_vld_o", int'(vld_o), 0);
    exp_q.delete();
    v_prev   = 1'b0;
    nval     = 0;
    last_out = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 12'h123, 'h123);
    cyc(1'b0, 1'b1, 12'h000, -1);
    cyc(1'b0, 1'b1, 12'h000, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
